// File: rtl/tgate_bus_if.sv
// Select/gate bundle between the datapath control logic and the
// transmission-gate bus controller.
interface tgate_bus_if #(
  parameter int N  = 4,
  parameter int SW = 2
);
  logic          sel_valid;
  logic [SW-1:0] sel;
  logic          sel_ready;
  logic          off_req;
  logic [N-1:0]  n_gate;
  logic [N-1:0]  p_gate;
  logic [SW-1:0] active;
  logic          bus_on;
  logic          overlap_err;

  modport master (
    output sel_valid, sel, off_req,
    input  sel_ready, n_gate, p_gate, active, bus_on, overlap_err
  );

  modport slave (
    input  sel_valid, sel, off_req,
    output sel_ready, n_gate, p_gate, active, bus_on, overlap_err
  );
endinterface

// File: rtl/tgate_bus_ctrl.sv
// Break-before-make controller for N transmission-gate switches on one bus node.
// Optional output overlap checker enabled by defining TGATE_OVERLAP_CHECK_EN.
module tgate_bus_ctrl #(
  parameter int N    = 4,
  parameter int SW   = 2,
  parameter int DEAD = 2
) (
  input logic        clk,
  input logic        reset,
  tgate_bus_if.slave bus
);
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_BREAK = 2'd1;
  localparam logic [1:0]  S_ON    = 2'd2;
  localparam logic [SW:0] N_LIM   = (SW+1)'(N);
  localparam logic [3:0]  DEAD_M1 = 4'(DEAD - 1);

  function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
    return N'(1) << idx;
  endfunction

  logic [1:0]    state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [SW-1:0] pending, pending_nx;
  logic          pend_vld, pend_vld_nx;
  logic [SW-1:0] active_r, active_nx;
  logic [N-1:0]  n_gate_r, p_gate_r, gate_nx;
  logic          bus_on_r;
  logic          accept, in_range;

  assign bus.sel_ready = (state != S_BREAK) && !bus.off_req;
  assign accept        = bus.sel_valid && bus.sel_ready;
  assign in_range      = {1'b0, bus.sel} < N_LIM;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pending_nx  = pending;
    pend_vld_nx = pend_vld;
    active_nx   = active_r;
    case (state)
      S_IDLE: begin
        if (accept && in_range) begin
          state_nx  = S_ON;
          active_nx = bus.sel;
        end
      end
      S_ON: begin
        // Out-of-range selects behave exactly like a disconnect request
        if (bus.off_req || (accept && !in_range)) begin
          state_nx    = S_BREAK;
          cnt_nx      = DEAD_M1;
          pend_vld_nx = 1'b0;
        end else if (accept && (bus.sel != active_r)) begin
          state_nx    = S_BREAK;
          cnt_nx      = DEAD_M1;
          pending_nx  = bus.sel;
          pend_vld_nx = 1'b1;
        end
      end
      S_BREAK: begin
        if (bus.off_req) pend_vld_nx = 1'b0;
        if (cnt == 4'd0) begin
          if (pend_vld && !bus.off_req) begin
            state_nx  = S_ON;
            active_nx = pending;
          end else begin
            state_nx = S_IDLE;
          end
          pend_vld_nx = 1'b0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    gate_nx = (state_nx == S_ON) ? onehot(active_nx) : '0;
  end

  // Registered gate drive: derived from next state so latency is one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pend_vld <= 1'b0;
      active_r <= '0;
      n_gate_r <= '0;
      p_gate_r <= '1;
      bus_on_r <= 1'b0;
    end else begin
      state    <= state_nx;
      pend_vld <= pend_vld_nx;
      active_r <= active_nx;
      n_gate_r <= gate_nx;
      p_gate_r <= ~gate_nx;
      bus_on_r <= (state_nx == S_ON);
    end
  end

  // Counter and pending index are only read while qualified by state/pend_vld
  always_ff @(posedge clk) begin
    cnt     <= cnt_nx;
    pending <= pending_nx;
  end

  assign bus.n_gate = n_gate_r;
  assign bus.p_gate = p_gate_r;
  assign bus.active = active_r;
  assign bus.bus_on = bus_on_r;

`ifdef TGATE_OVERLAP_CHECK_EN
  function automatic logic multi_hot(input logic [N-1:0] x);
    return (x & (x - N'(1))) != '0;
  endfunction

  logic overlap_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      overlap_r <= 1'b0;
    end else if (multi_hot(n_gate_r) || (|(~(n_gate_r ^ p_gate_r)))) begin
      overlap_r <= 1'b1;
    end
  end

  assign bus.overlap_err = overlap_r;
`else
  assign bus.overlap_err = 1'b0;
`endif

endmodule

// File: tb/tb_tgate_bus_ctrl.sv
// Scoreboard bench for tgate_bus_ctrl: timeline reference model feeds a queue
// that a negedge monitor drains and compares against the outputs.
module tb_tgate_bus_ctrl;
  localparam int N    = 4;
  localparam int SW   = 3;
  localparam int DEAD = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tgate_bus_if #(.N(N), .SW(SW)) bif ();

  tgate_bus_ctrl #(.N(N), .SW(SW), .DEAD(DEAD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic [N-1:0]  n;
    logic [N-1:0]  p;
    logic [SW-1:0] act;
    bit            on;
    bit            rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: connection as an index (-1 = none) plus the edge at
  // which an open-all interval ends and the target it then connects.
  bit known = 0;
  int conn = -1;
  int target = -1;
  bit in_break = 0;
  int reopen_edge = 0;
  int last_active = 0;
  int edge_no = 0;

  task automatic model_edge(input bit v, input int s, input bit o, input bit r);
    bit acc;
    edge_no++;
    acc = v && !in_break && !o;
    if (r) begin
      known = 1; conn = -1; target = -1; in_break = 0; last_active = 0;
    end else if (in_break) begin
      if (o) target = -1;
      if (edge_no == reopen_edge) begin
        in_break = 0;
        conn = target;
        if (target >= 0) last_active = target;
      end
    end else if (conn >= 0) begin
      if (o || (acc && s >= N) || (acc && s != conn)) begin
        target = (o || s >= N) ? -1 : s;
        in_break = 1;
        reopen_edge = edge_no + DEAD;
        conn = -1;
      end
    end else if (acc && s < N) begin
      conn = s;
      last_active = s;
    end
  endtask

  task automatic step(input bit v, input int s, input bit o, input bit r);
    exp_t e;
    bif.sel_valid = v;
    bif.sel       = SW'(s);
    bif.off_req   = o;
    reset         = r;
    if (known) begin
      e.n   = (conn >= 0) ? (N'(1) << conn) : '0;
      e.p   = ~e.n;
      e.act = SW'(last_active);
      e.on  = (conn >= 0);
      e.rdy = !in_break && !o;
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_edge(v, s, o, r);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("n_gate", int'(bif.n_gate), int'(e.n));
        chk("p_gate", int'(bif.p_gate), int'(e.p));
        chk("active", int'(bif.active), int'(e.act));
        chk("bus_on", int'(bif.bus_on), int'(e.on));
        chk("sel_ready", int'(bif.sel_ready), int'(e.rdy));
        chk("overlap_err", int'(bif.overlap_err), 0);
        chk("single_on", int'($countones(bif.n_gate) <= 1), 1);
        chk("complement", int'((bif.n_gate ^ bif.p_gate) == '1), 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bif.sel_valid = 1'b0;
    bif.sel       = '0;
    bif.off_req   = 1'b0;
    // Reset, then connect 2, hop to 1, re-issue 1
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 2, 0, 0); step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 1, 0, 0); step(0, 0, 0, 0);
    // off_req together with a select while ON
    step(1, 3, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // Out-of-range select while ON and while IDLE
    step(1, 2, 0, 0); step(1, 5, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 7, 0, 0); step(0, 0, 0, 0);
    // Reset mid-BREAK drops the pending index
    step(1, 2, 0, 0); step(1, 3, 0, 0); step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // off_req during BREAK cancels the pending connection
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 499) == 0);
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
